sram_sweep_ctrl: RTL and testbench
==================================

Name: sram_sweep_ctrl

Overview:
- Responder side of the start/rnw/stop/ready sweep protocol used by the memory tester.
- On a start pulse, sweeps the whole asynchronous SRAM from address 0 to the top, one word at a time, either writing caller data or reading data back.
- Pulses ready once per word and stop once per sweep.
- Sits between the tester FSM / random-vector generator and the SRAM pins.

Parameters:
SRAM_DATA_SIZE, 8, width of data bus
SRAM_ADDR_SIZE, 19, width of address bus; sweep length is 2^SRAM_ADDR_SIZE words
ACC_CYCLES, 1, number of clocks the WE_N/OE_N strobe is held low (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a sweep at address 0
rnw  in  1  sampled with start: 1 = read sweep, 0 = write sweep
ready  out  1  one-cycle pulse per completed word
stop  out  1  one-cycle pulse after the last word of a sweep
wdat  in  SRAM_DATA_SIZE  write data for the current word
rdat  out  SRAM_DATA_SIZE  read data; valid while ready=1 in a read sweep
SRAM_DQ  inout  SRAM_DATA_SIZE  SRAM data bus
SRAM_ADDR  out  SRAM_ADDR_SIZE  SRAM address
SRAM_CE_N  out  1  chip enable, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_WE_N  out  1  write enable, active low

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Registered outputs: all outputs are registered. SRAM_DQ is driven only from a registered output-enable.
- Reset values: state IDLE, ready=0, stop=0, rdat=0, SRAM_ADDR=0, SRAM_CE_N=1, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_DQ=Z, mode latch=read.
- States: IDLE, SETUP, STROBE, LAST, DONE.
- IDLE:
  - All strobes high.
  - On start, latch rnw, clear the address to 0, go to SETUP.
- SETUP (1 clk):
  - CE_N=0; address stable.
  - Write: register wdat and drive it onto DQ.
  - Read: DQ=Z.
  - Go to STROBE.
- STROBE (ACC_CYCLES clks):
  - Write: WE_N=0, DQ driven.
  - Read: OE_N=0.
  - On the edge leaving the final STROBE clock, read mode captures SRAM_DQ into rdat.
  - Go to LAST.
- LAST (1 clk):
  - WE_N=1; DQ still driven in write mode (hold time). OE_N=1.
  - ready=1.
  - If address = all-ones: go to DONE. Otherwise increment the address and go to SETUP.
- DONE (1 clk):
  - stop=1, CE_N=1, DQ=Z, address wraps to 0.
  - Go to IDLE.
- Timing:
  - One word takes 2+ACC_CYCLES clocks.
  - First ready occurs 2+ACC_CYCLES clocks after the start-sampling edge.
  - stop occurs one clock after the final ready.
  - A sweep takes 2^A*(2+ACC_CYCLES)+1 clocks from start to stop.
- wdat contract:
  - Sampled only in SETUP.
  - The caller may advance its source on ready; the new value is seen in the next SETUP.
- rdat contract: rdat holds its value until the next capture.
- start while busy (any state other than IDLE):
  - Aborts the current word. Strobes go high on the next clock.
  - rnw is relatched, the address goes to 0, and the next state is SETUP.
  - No ready and no stop are issued for the aborted word or sweep.
- start coincident with the LAST cycle of the final word: the ready already on the wire stands; no stop follows; the new sweep begins.
- rst mid-sweep: next clock returns to the reset values; no ready or stop is issued.
- rnw is ignored except on start cycles.
- Bus contention: DQ is never driven while OE_N=0, and is never driven in read mode.

Test Plan:
- Reset: after rst=1 for 2 clks -> ready=0, stop=0, CE_N/OE_N/WE_N=1, DQ=Z, ADDR=0.
- Write sweep (A=3, ACC=1, wdat=addr^0xA5 advanced on ready) -> 8 ready pulses spaced 3 clks; WE_N low exactly 1 clk per word; SRAM model holds addr^0xA5; stop 1 clk after the 8th ready; 25 clks from start to stop.
- Read sweep after the write -> rdat at each ready equals addr^0xA5 for addr 0..7; DQ never driven; single stop.
- ACC_CYCLES=3 read -> ready spacing 5 clks; OE_N low 3 clks per word; 41 clks from start to stop.
- Restart: start (write) at word 4 -> WE_N high next clk; next SETUP at ADDR=0; 8 further ready pulses then 1 stop, with no stop for the aborted sweep.
- rst asserted during STROBE of word 2 -> all strobes high and DQ=Z next clk; no ready or stop; a subsequent start performs a full 8-word sweep.

Source files
------------

// File: rtl/sram_sweep_ctrl.sv
// sram_sweep_ctrl: sweeps an async SRAM from address 0 to the top,
// writing caller data or reading it back, one word per 2+ACC_CYCLES clks.
module sram_sweep_ctrl #(
  parameter int SRAM_DATA_SIZE = 8,
  parameter int SRAM_ADDR_SIZE = 19,
  parameter int ACC_CYCLES     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      rnw,
  output logic                      ready,
  output logic                      stop,
  input  logic [SRAM_DATA_SIZE-1:0] wdat,
  output logic [SRAM_DATA_SIZE-1:0] rdat,
  inout  wire  [SRAM_DATA_SIZE-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_SIZE-1:0] SRAM_ADDR,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N
);

  localparam int DW = SRAM_DATA_SIZE;
  localparam int AW = SRAM_ADDR_SIZE;
  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    LAST,
    DONE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] addr_d;
  logic          mode;
  logic          mode_d;
  logic          dq_oe;
  logic [DW-1:0] dq_out;
  logic          last_strobe;
  logic          busy_d;
  logic          strobe_d;
  logic          cap;
  logic          load;

  assign last_strobe = (cnt == CW'(ACC_CYCLES - 1));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = SRAM_ADDR;
    mode_d  = mode;
    if (start) begin
      state_d = SETUP;
      cnt_d   = '0;
      addr_d  = '0;
      mode_d  = rnw;
    end else begin
      unique case (state)
        IDLE: state_d = IDLE;
        SETUP: begin
          state_d = STROBE;
          cnt_d   = '0;
        end
        STROBE: begin
          if (last_strobe) state_d = LAST;
          else cnt_d = cnt + CW'(1);
        end
        LAST: begin
          // increment also wraps the top address back to 0 for DONE
          addr_d  = SRAM_ADDR + AW'(1);
          state_d = (&SRAM_ADDR) ? DONE : SETUP;
        end
        DONE: begin
          addr_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d   = (state_d == SETUP) ||
               (state_d == STROBE) ||
               (state_d == LAST);
    strobe_d = (state_d == STROBE);
    cap      = (state == STROBE) && last_strobe &&
               mode && !start;
    load     = (state == SETUP) && !start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b1;
      SRAM_ADDR <= '0;
      ready     <= 1'b0;
      stop      <= 1'b0;
      rdat      <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mode      <= mode_d;
      SRAM_ADDR <= addr_d;
      ready     <= (state_d == LAST);
      stop      <= (state_d == DONE);
      SRAM_CE_N <= !busy_d;
      SRAM_WE_N <= !(strobe_d && !mode_d);
      SRAM_OE_N <= !(strobe_d && mode_d);
      // bus only ever driven in write mode, so never against OE_N
      dq_oe     <= busy_d && !mode_d;
      if (cap) rdat <= SRAM_DQ;
      if (load) dq_out <= wdat;
    end
  end

  assign SRAM_DQ = dq_oe ? dq_out : 'z;

endmodule

// File: tb/tb_sram_sweep_ctrl.sv
// tb_sram_sweep_ctrl: two controllers (ACC_CYCLES 1 and 3) on 8-word
// SRAM models, checked each cycle against a sweep-timing model.
module tb_sram_sweep_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] rnw;
  logic       en = 1'b0;

  wire  [1:0] ready;
  wire  [1:0] stop;
  wire  [1:0] ce_n;
  wire  [1:0] oe_n;
  wire  [1:0] we_n;
  wire  [2:0] addr [2];
  wire  [7:0] rdat [2];
  wire  [7:0] wdat [2];
  wire  [7:0] dq0;
  wire  [7:0] dq1;

  logic [7:0] mem  [2][N];
  logic [7:0] emem [2][N];
  logic [7:0] idx  [2];
  int         t    [2];
  logic       wr   [2];
  logic [7:0] erd  [2];

  int n_tests = 0;
  int n_fail  = 0;
  int s_cyc, s_rdy, s_we, s_oe, s_stop, s_gap;
  logic [7:0] rq [$];

  initial forever #5 clk = ~clk;

  sram_sweep_ctrl #(
    .SRAM_DATA_SIZE(8), .SRAM_ADDR_SIZE(3), .ACC_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .rnw(rnw[0]),
    .ready(ready[0]), .stop(stop[0]), .wdat(wdat[0]),
    .rdat(rdat[0]), .SRAM_DQ(dq0), .SRAM_ADDR(addr[0]),
    .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0]),
    .SRAM_WE_N(we_n[0])
  );

  sram_sweep_ctrl #(
    .SRAM_DATA_SIZE(8), .SRAM_ADDR_SIZE(3), .ACC_CYCLES(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .rnw(rnw[1]),
    .ready(ready[1]), .stop(stop[1]), .wdat(wdat[1]),
    .rdat(rdat[1]), .SRAM_DQ(dq1), .SRAM_ADDR(addr[1]),
    .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1]),
    .SRAM_WE_N(we_n[1])
  );

  // SRAM devices
  assign dq0 = (!ce_n[0] && !oe_n[0]) ? mem[0][addr[0]] : 'z;
  assign dq1 = (!ce_n[1] && !oe_n[1]) ? mem[1][addr[1]] : 'z;

  always @(negedge clk) begin
    if (!ce_n[0] && !we_n[0]) mem[0][addr[0]] <= dq0;
    if (!ce_n[1] && !we_n[1]) mem[1][addr[1]] <= dq1;
  end

  // caller: data source advances on every ready
  assign wdat[0] = idx[0] ^ 8'hA5;
  assign wdat[1] = idx[1] ^ 8'hA5;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst || start[g]) idx[g] <= 8'd0;
      else if (ready[g]) idx[g] <= idx[g] + 8'd1;
    end
  end

  function automatic int acc_of(int g);
    return g ? 3 : 1;
  endfunction

  function automatic int wlen(int g);
    return 2 + acc_of(g);
  endfunction

  function automatic int nxt_t(int g);
    if (start[g]) return 0;
    if (t[g] >= 0 && t[g] < N * wlen(g)) return t[g] + 1;
    return -1;
  endfunction

  function automatic logic nxt_wr(int g);
    return start[g] ? !rnw[g] : wr[g];
  endfunction

  function automatic logic is_last(int g, int tt);
    return tt >= 0 && tt < N * wlen(g) &&
           (tt % wlen(g)) == wlen(g) - 1;
  endfunction

  // model: t = clocks since the start edge, -1 when idle
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        t[g]   <= -1;
        wr[g]  <= 1'b0;
        erd[g] <= 8'd0;
      end else begin
        t[g]  <= nxt_t(g);
        wr[g] <= nxt_wr(g);
        if (is_last(g, nxt_t(g))) begin
          if (nxt_wr(g))
            emem[g][nxt_t(g) / wlen(g)] <=
              8'(nxt_t(g) / wlen(g)) ^ 8'hA5;
          else
            erd[g] <= emem[g][nxt_t(g) / wlen(g)];
        end
      end
    end
  end

  // {ready, stop, ce_n, oe_n, we_n, addr}
  function automatic logic [7:0] exp_ctl(int g);
    int w, p;
    logic s;
    logic [7:0] e;
    e = 8'b0011_1000;
    if (t[g] >= 0 && t[g] < N * wlen(g)) begin
      w = t[g] / wlen(g);
      p = t[g] % wlen(g);
      s = (p >= 1) && (p <= acc_of(g));
      e = {p == wlen(g) - 1, 1'b0, 1'b0,
           !(s && !wr[g]), !(s && wr[g]), 3'(w)};
    end else if (t[g] == N * wlen(g)) begin
      e = 8'b0111_1000;
    end
    return e;
  endfunction

  function automatic logic [7:0] dq_of(int g);
    return g ? dq1 : dq0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ctl%0d", g),
            {ready[g], stop[g], ce_n[g], oe_n[g], we_n[g], addr[g]},
            exp_ctl(g));
        chk($sformatf("rdat%0d", g), rdat[g], erd[g]);
        if (wr[g] && t[g] >= 0 && t[g] < N * wlen(g) &&
            (t[g] % wlen(g)) != 0)
          chk($sformatf("wdq%0d", g), dq_of(g),
              8'(t[g] / wlen(g)) ^ 8'hA5);
        if (!oe_n[g])
          chk($sformatf("rdq%0d", g), dq_of(g), mem[g][addr[g]]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int g, input logic rd);
    start[g] = 1'b1;
    rnw[g]   = rd;
    step(1);
    start[g] = 1'b0;
    rnw[g]   = 1'b0;
  endtask

  // counts events from now until stop; s_cyc = -1 if none arrives
  task automatic watch(input int g, input int max);
    int last;
    s_rdy = 0; s_we = 0; s_oe = 0; s_stop = 0; s_gap = 0;
    s_cyc = -1;
    last  = -1;
    rq.delete();
    for (int k = 1; k <= max; k++) begin
      if (ready[g]) begin
        s_rdy++;
        rq.push_back(rdat[g]);
        if (s_gap == 0 && last >= 0) s_gap = k - last;
        last = k;
      end
      if (!we_n[g]) s_we++;
      if (!oe_n[g]) s_oe++;
      if (stop[g]) begin
        s_stop++;
        s_cyc = k;
        return;
      end
      step(1);
    end
  endtask

  task automatic wait_cond(input int g, input int a,
                           input logic on_ready);
    int k;
    for (k = 0; k < 200; k++) begin
      if (addr[g] == 3'(a) &&
          (on_ready ? ready[g] : !we_n[g])) break;
      step(1);
    end
    chk("wait_cond", k < 200, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 2'b00;
    rnw   = 2'b00;
    step(2);
    chk("rst_ctl", {ready[0], stop[0], ce_n[0], oe_n[0],
                    we_n[0], addr[0]}, 8'b0011_1000);
    chk("rst_rdat", rdat[0], 8'h00);
    en  = 1'b1;
    rst = 1'b0;
    step(1);

    // write sweep, ACC=1
    pulse_start(0, 1'b0);
    watch(0, 100);
    chk("wr_cyc", s_cyc, 25);
    chk("wr_rdy", s_rdy, 8);
    chk("wr_we", s_we, 8);
    chk("wr_gap", s_gap, 3);
    chk("mem3", mem[0][3], 8'hA6);
    chk("mem7", mem[0][7], 8'hA2);
    step(2);

    // read sweep, ACC=1
    pulse_start(0, 1'b1);
    watch(0, 100);
    chk("rd_cyc", s_cyc, 25);
    chk("rd_oe", s_oe, 8);
    chk("rd_we", s_we, 0);
    chk("rd_n", rq.size(), 8);
    chk("rd_q0", rq[0], 8'hA5);
    chk("rd_q5", rq[5], 8'hA0);
    step(2);

    // ACC=3: fill then read back
    pulse_start(1, 1'b0);
    watch(1, 200);
    chk("b_wr_cyc", s_cyc, 41);
    chk("b_wr_we", s_we, 24);
    step(2);
    pulse_start(1, 1'b1);
    watch(1, 200);
    chk("b_rd_cyc", s_cyc, 41);
    chk("b_rd_oe", s_oe, 24);
    chk("b_rd_gap", s_gap, 5);
    chk("b_rd_q2", rq[2], 8'hA7);
    step(2);

    // restart during word 4 strobe
    pulse_start(0, 1'b0);
    wait_cond(0, 4, 1'b0);
    pulse_start(0, 1'b0);
    watch(0, 100);
    chk("rs_cyc", s_cyc, 25);
    chk("rs_rdy", s_rdy, 8);
    chk("rs_stop", s_stop, 1);
    step(2);

    // start on the final LAST cycle
    pulse_start(0, 1'b1);
    wait_cond(0, 7, 1'b1);
    pulse_start(0, 1'b0);
    watch(0, 100);
    chk("fl_cyc", s_cyc, 25);
    chk("fl_rdy", s_rdy, 8);
    step(2);

    // reset during word 2 strobe
    pulse_start(0, 1'b0);
    wait_cond(0, 2, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rm_ctl", {ce_n[0], oe_n[0], we_n[0], ready[0], stop[0]},
        5'b11100);
    watch(0, 12);
    chk("rm_rdy", s_rdy, 0);
    chk("rm_stop", s_cyc, -1);
    pulse_start(0, 1'b0);
    watch(0, 100);
    chk("rm_full", s_rdy, 8);
    chk("rm_cyc", s_cyc, 25);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
